// File: rtl/ef_i2s_pkg.sv
// Shared definitions for the EF_I2S master timing sequencer.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package ef_i2s_pkg;

  // Sequencer states, kept as plain constants so older tools can consume them too
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // A sample size of 0, or one larger than the slot, means "use the full slot"
  function automatic int unsigned clamp_sample_size(input int unsigned ss,
                                                    input int unsigned slot_bits);
    if (ss == 0 || ss > slot_bits) return slot_bits;
    return ss;
  endfunction

endpackage

// File: rtl/ef_i2s_sck_div.sv
// Prescaler counter and sck register; flags the edge on which sck toggles.
// Latency: sck toggles prescaler+1 clocks after load, then every prescaler+1 clocks.
// Backpressure: none; free-running while not held in load.
module ef_i2s_sck_div #(
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_load,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               o_sck,
  output logic               o_rise,
  output logic               o_fall
);

  logic [PRESC_W-1:0] r_cnt;
  logic               r_sck;
  logic               w_tick;

  // rise/fall are combinational: they mark the clock edge on which r_sck changes,
  // so the parent can register its strobes in step with the new sck level.
  assign w_tick = !i_load && (r_cnt == '0);
  assign o_rise = w_tick && !r_sck;
  assign o_fall = w_tick && r_sck;
  assign o_sck  = r_sck;

  // Count down to zero, then reload and toggle; load parks sck low with a fresh count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_presc;
      r_sck <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= i_presc;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt - PRESC_W'(1);
    end
  end

endmodule

// File: rtl/ef_i2s_master_seq.sv
// I2S master sequencer: drives sck/ws and per-bit capture strobes for the receive path.
// Latency: first sck edge prescaler+1 clocks after en is seen; all outputs registered.
// Backpressure: none; dropping en finishes the current L/R frame before going idle.
module ef_i2s_master_seq
  import ef_i2s_pkg::*;
#(
  parameter int SLOT_BITS = 32,
  parameter int PRESC_W   = 8,
  parameter int BITS_W    = $clog2(SLOT_BITS) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en,
  input  logic [PRESC_W-1:0] prescaler,
  input  logic [BITS_W-1:0] sample_size,
  output logic              sck,
  output logic              ws,
  output logic              sample_en,
  output logic [BITS_W-1:0] bit_idx,
  output logic              chan,
  output logic              word_done,
  output logic              busy
);

  localparam logic [BITS_W-1:0] LAST_POS = BITS_W'(SLOT_BITS - 1);

  logic [1:0]         r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [BITS_W-1:0]  r_ss;
  logic [BITS_W-1:0]  r_pos;
  logic               r_ws;
  logic               r_first;       // still inside the pre-start dummy slot
  logic               r_dummy_prev;  // slot just ended was the dummy one
  logic               r_stop_req;
  logic               r_sample_en;
  logic [BITS_W-1:0]  r_bit_idx;
  logic               r_chan;
  logic               r_word_done;
  logic               r_busy;

  logic               w_idle;
  logic               w_stop_done;
  logic               w_div_load;
  logic [PRESC_W-1:0] w_div_presc;
  logic               w_rise;
  logic               w_fall;
  logic [BITS_W-1:0]  w_d;
  logic               w_c;
  logic               w_skip;
  logic               w_strobe;

  assign w_idle = (r_state == ST_IDLE);

  // Right word has just completed while a stop is pending and en stays low
  assign w_stop_done = r_stop_req && r_word_done && r_chan && !en;

  // Divider is held in load while idle (picks up the live prescaler) and on the
  // stop edge so sck returns low together with ws.
  assign w_div_load  = w_idle || w_stop_done;
  assign w_div_presc = w_idle ? prescaler : r_presc;

  ef_i2s_sck_div #(.PRESC_W(PRESC_W)) u_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (w_div_load),
    .i_presc (w_div_presc),
    .o_sck   (sck),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // One-bit I2S delay: the bit seen at slot position 0 is the LSB-end of the previous slot
  assign w_d = (r_pos == '0) ? LAST_POS : (r_pos - BITS_W'(1));
  assign w_c = (r_pos == '0) ? ~r_ws : r_ws;

  // Nothing is captured from the dummy slot, including its delayed bit at position 0
  assign w_skip   = r_first || ((r_pos == '0) && r_dummy_prev);
  assign w_strobe = w_rise && !w_skip && (w_d < r_ss);

  // FSM, slot position, word select and capture strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_presc      <= '0;
      r_ss         <= '0;
      r_pos        <= '0;
      r_ws         <= 1'b0;
      r_first      <= 1'b0;
      r_dummy_prev <= 1'b0;
      r_stop_req   <= 1'b0;
      r_sample_en  <= 1'b0;
      r_bit_idx    <= '0;
      r_chan       <= 1'b0;
      r_word_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_sample_en <= 1'b0;
      r_word_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state      <= ST_RUN;
            r_busy       <= 1'b1;
            r_presc      <= prescaler;
            r_ss         <= BITS_W'(clamp_sample_size(32'(sample_size), SLOT_BITS));
            r_pos        <= LAST_POS;
            r_first      <= 1'b1;
            r_dummy_prev <= 1'b0;
            r_ws         <= 1'b0;
            r_stop_req   <= 1'b0;
          end
        end
        ST_RUN, ST_STOP: begin
          if (w_stop_done) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_stop_req   <= 1'b0;
            r_pos        <= '0;
            r_ws         <= 1'b0;
            r_first      <= 1'b0;
            r_dummy_prev <= 1'b0;
            r_bit_idx    <= '0;
            r_chan       <= 1'b0;
          end else begin
            if (r_state == ST_RUN && !en) begin
              r_state    <= ST_STOP;
              r_stop_req <= 1'b1;
            end else if (r_state == ST_STOP && en) begin
              r_state    <= ST_RUN;
              r_stop_req <= 1'b0;
            end
            if (w_fall) begin
              if (r_pos == LAST_POS) begin
                r_pos <= '0;
                if (r_first) begin
                  r_ws         <= 1'b0;
                  r_first      <= 1'b0;
                  r_dummy_prev <= 1'b1;
                end else begin
                  r_ws <= ~r_ws;
                end
              end else begin
                r_pos <= r_pos + BITS_W'(1);
              end
            end
            if (w_rise) begin
              r_dummy_prev <= 1'b0;
              if (w_strobe) begin
                r_sample_en <= 1'b1;
                r_bit_idx   <= w_d;
                r_chan      <= w_c;
                r_word_done <= (w_d == r_ss - BITS_W'(1));
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ws        = r_ws;
  assign sample_en = r_sample_en;
  assign bit_idx   = r_bit_idx;
  assign chan      = r_chan;
  assign word_done = r_word_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ef_i2s_master_seq.sv
// Bench for ef_i2s_master_seq: scoreboard of expected capture strobes.
// Latency: n/a.
// Backpressure: n/a.
module tb_ef_i2s_master_seq;

  localparam int SLOT = 32;
  localparam int PW   = 8;
  localparam int BW   = $clog2(SLOT) + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          en = 1'b0;
  logic [PW-1:0] prescaler = '0;
  logic [BW-1:0] sample_size = '0;
  logic          sck, ws, sample_en, chan, word_done, busy;
  logic [BW-1:0] bit_idx;

  ef_i2s_master_seq #(.SLOT_BITS(SLOT), .PRESC_W(PW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .en          (en),
    .prescaler   (prescaler),
    .sample_size (sample_size),
    .sck         (sck),
    .ws          (ws),
    .sample_en   (sample_en),
    .bit_idx     (bit_idx),
    .chan        (chan),
    .word_done   (word_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the index of the posedge just taken
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc_n;
    int bit_n;
    bit ch;
    bit wd;
    bit ws_e;
  } exp_t;

  exp_t q[$];

  // Written only by the stimulus process
  int idle_chk_cyc = -1;
  int busy_chk_cyc = -1;
  bit rst_probe    = 1'b0;

  // Written only by the monitor process
  int n_cmp = 0;
  int n_bad = 0;
  bit rst_seen = 1'b0;

  // Monitor: pops the scoreboard on every strobe, plus point checks requested by stimulus
  always begin
    exp_t e;
    @(negedge clk or rst_probe);
    if (rst_probe != rst_seen) begin
      rst_seen = rst_probe;
      n_cmp++;
      if ({sck, ws, sample_en, bit_idx, chan, word_done, busy} != '0) begin
        n_bad++;
        $display("FAIL reset_outputs: sck=%0b ws=%0b sample_en=%0b bit_idx=%0d chan=%0b word_done=%0b busy=%0b, required all 0",
                 sck, ws, sample_en, bit_idx, chan, word_done, busy);
      end
      q.delete();
    end else begin
      if (sample_en) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL strobe_unexpected: cyc=%0d bit_idx=%0d chan=%0b, required no strobe", cyc, bit_idx, chan);
        end else begin
          e = q.pop_front();
          if (e.cyc_n != cyc || int'(bit_idx) != e.bit_n || chan != e.ch ||
              word_done != e.wd || ws != e.ws_e || sck != 1'b1) begin
            n_bad++;
            $display("FAIL strobe: got cyc=%0d bit=%0d chan=%0b wd=%0b ws=%0b sck=%0b, required cyc=%0d bit=%0d chan=%0b wd=%0b ws=%0b sck=1",
                     cyc, bit_idx, chan, word_done, ws, sck, e.cyc_n, e.bit_n, e.ch, e.wd, e.ws_e);
          end
        end
      end else begin
        if (word_done) begin
          n_cmp++;
          n_bad++;
          $display("FAIL word_done_alone: cyc=%0d word_done=1, required 0 without sample_en", cyc);
        end
        if (q.size() > 0 && q[0].cyc_n < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL strobe_missing: cyc=%0d no strobe, required bit=%0d chan=%0b at cyc=%0d",
                   cyc, q[0].bit_n, q[0].ch, q[0].cyc_n);
          void'(q.pop_front());
        end
      end
      if (cyc == busy_chk_cyc) begin
        n_cmp++;
        if ({busy, sck, ws} != 3'b100) begin
          n_bad++;
          $display("FAIL run_start: busy=%0b sck=%0b ws=%0b, required busy=1 sck=0 ws=0", busy, sck, ws);
        end
      end
      if (cyc == idle_chk_cyc) begin
        n_cmp++;
        if ({busy, sck, ws} != 3'b000 || q.size() != 0) begin
          n_bad++;
          $display("FAIL stop_idle: busy=%0b sck=%0b ws=%0b pending=%0d, required busy=0 sck=0 ws=0 pending=0",
                   busy, sck, ws, q.size());
        end
      end
    end
  end

  // One run from IDLE. Offsets are in clocks from the edge that sees en=1.
  // Reference: the n-th bit after the dummy slot and its delayed first edge is captured on
  // sck rise 2n+5 half-periods after start; it is bit n%SLOT of slot n/SLOT (even = left).
  task automatic session(input int p, input int sin, input int drop_off,
                         input int dip_off, input int dip_len, input int rst_off);
    int h, s, e0, d0, d1, es, w_last, n, stop_at;
    @(negedge clk);
    prescaler   = PW'(p);
    sample_size = BW'(sin);
    en          = 1'b1;
    e0 = cyc + 1;
    h  = p + 1;
    s  = (sin == 0 || sin > SLOT) ? SLOT : sin;
    d0 = (dip_len > 0) ? e0 + dip_off : -10;
    d1 = d0 + dip_len;
    es = e0 + drop_off;
    w_last = -1;
    n = 0;
    while (w_last < 0 && n < 20000) begin
      int ed, slot, b;
      bit ch;
      ed   = e0 + (2 * n + 5) * h;
      slot = n / SLOT;
      b    = n % SLOT;
      ch   = slot[0];
      if (b < s) begin
        q.push_back('{ed, b, ch, (b == s - 1), (b == SLOT - 1) ? ~ch : ch});
        // A completed right word ends the run if en is low on the following edge
        if (b == s - 1 && ch && ((ed >= d0 && ed + 1 < d1) || ed >= es)) w_last = ed;
      end
      n++;
    end
    busy_chk_cyc = e0;
    idle_chk_cyc = (rst_off > 0) ? -1 : w_last + 1;
    stop_at      = (rst_off > 0) ? e0 + rst_off : w_last + 3;
    while (cyc < stop_at) begin
      if (cyc + 1 == e0 + 3) begin
        // Inputs changed while busy must not affect the running sequence
        prescaler   = PW'($urandom);
        sample_size = BW'($urandom);
      end
      if (cyc + 1 == d0) en = 1'b0;
      if (cyc + 1 == d1) en = 1'b1;
      if (cyc + 1 == es) en = 1'b0;
      @(negedge clk);
    end
    if (rst_off > 0) begin
      #2;
      rst_i = 1'b1;
      en    = 1'b0;
      #1;
      rst_probe = ~rst_probe;
      @(negedge clk);
      rst_i = 1'b0;
    end
  endtask

  initial begin
    #1;
    rst_i = 1'b1;
    #1;
    rst_probe = ~rst_probe;
    #20;
    @(negedge clk);
    rst_i = 1'b0;

    session(1, 24, 300, 0, 0, 0);   // base case, sck period 4
    session(0, 32, 100, 0, 0, 0);   // full slot: p=0 rise carries bit 31
    session(2, 0, 200, 0, 0, 0);    // 0 clamps to full slot
    session(1, 40, 150, 0, 0, 0);   // oversize clamps to full slot
    session(1, 24, 40, 0, 0, 0);    // stop requested mid left word
    session(2, 16, 400, 90, 3, 0);  // brief en dip: no stop
    session(3, 24, 250, 0, 0, 0);
    session(1, 24, 1000, 0, 0, 150); // async reset mid word
    session(1, 24, 60, 0, 0, 0);    // clean restart after reset
    for (int i = 0; i < 6; i++) begin
      int p, sz, h;
      p  = $urandom_range(0, 3);
      sz = $urandom_range(0, 63);
      h  = p + 1;
      session(p, sz, $urandom_range(40 * h, 200 * h),
              30 * h, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0, 0);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
